// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR, imem req/ack handshake and next-PC selection
module fetch_unit #(
    parameter int          AW        = 16,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter int          RESET_PC  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_start,
    input  logic          pc_update,
    input  logic [1:0]    pc_src,
    input  logic          branch_taken,
    input  logic [AW-1:0] ret_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic [15:0]   ir,
    output logic [3:0]    opcode,
    output logic          m,
    output logic          ir_valid,
    output logic          busy,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus1,
    output logic          fetch_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam int         CW   = $clog2(TIMEOUT + 1);

    logic [0:0]    state;
    logic [CW-1:0] waitCnt;
    logic [AW-1:0] nextPc;
    logic [AW-1:0] branchOff;

    // Outputs derive from the state register so an async reset drops imem_req at once
    assign imem_req  = (state == WAIT);
    assign busy      = (state == WAIT);
    assign imem_addr = pc;
    assign opcode    = ir[15:12];
    assign m         = ir[11];
    assign pc_plus1  = pc + AW'(1);
    assign branchOff = {{(AW-5){ir[4]}}, ir[4:0]};

    always_comb begin
        nextPc = pc_plus1;
        case (pc_src)
            2'b00: nextPc = pc_plus1;
            2'b01: nextPc = {pc[AW-1:12], ir[11:0]};
            2'b10: nextPc = branch_taken ? (pc + branchOff) : pc_plus1;
            2'b11: nextPc = ret_addr;
            default: nextPc = pc_plus1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= AW'(RESET_PC);
            ir        <= 16'h0000;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            waitCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A same-cycle pc_update commits first; the fetch then uses the new pc
                    if (pc_update) begin
                        pc <= nextPc;
                    end
                    if (fetch_start) begin
                        state    <= WAIT;
                        ir_valid <= 1'b0;
                        waitCnt  <= '0;
                    end
                end
                WAIT: begin
                    if (pc_update) begin
                        fetch_err <= 1'b1;
                    end
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        state    <= IDLE;
                    end else if (waitCnt == CW'(TIMEOUT - 1)) begin
                        ir        <= NOP_INSTR;
                        ir_valid  <= 1'b1;
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
